// File: rtl/agu_stage_ctrl_if.sv
// Handshake bundle between the NTT controller, AGU_k1/AGU_k2 and agu_stage_ctrl.
// The slave modport is the sequencer's view; master is the environment's view.
interface agu_stage_ctrl_if #(
    parameter int D_WIDTH = 4
);
    logic               start;
    logic               abort;
    logic               AGU_done_k1;
    logic               AGU_done_k2;
    logic               AGU_enable_k1;
    logic               AGU_enable_k2;
    logic [D_WIDTH-1:0] l;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, AGU_done_k1, AGU_done_k2,
        input  AGU_enable_k1, AGU_enable_k2, l, busy, done, err
    );

    modport slave (
        input  start, abort, AGU_done_k1, AGU_done_k2,
        output AGU_enable_k1, AGU_enable_k2, l, busy, done, err
    );
endinterface

// File: rtl/agu_stage_ctrl.sv
// Stage sequencer for the NTT address generators: K1 passes, one K2 pass, pipeline drain, done.
// Define AGU_WDOG_EN to add a per-pass watchdog with a sticky ERR state (cleared by abort/rst).
module agu_stage_ctrl #(
    parameter int D_WIDTH      = 4,
    parameter int K1_STAGES    = 2,
    parameter int LAST_L       = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int WDOG_CYCLES  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    agu_stage_ctrl_if.slave   bus
);

    localparam int                 DR_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [D_WIDTH-1:0] K1_LIM  = D_WIDTH'(K1_STAGES);
    localparam logic [D_WIDTH-1:0] L_LAST  = D_WIDTH'(LAST_L);
    localparam logic [DR_W-1:0]    DR_LOAD = DR_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        K1_RUN = 3'd1,
        K1_GAP = 3'd2,
        K2_RUN = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
`ifdef AGU_WDOG_EN
        , ERR  = 3'd6
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [D_WIDTH-1:0] stage_q, stage_d, stage_inc;
    logic [D_WIDTH-1:0] l_q, l_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic               en1_q, en1_d;
    logic               en2_q, en2_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign stage_inc = stage_q + 1'b1;

`ifdef AGU_WDOG_EN
    localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            wdog_trip;
    logic            err_q, err_d;

    assign wdog_trip = (wdog_q == WD_LAST);

    // Restarts on every entry into a RUN state, counts only while resident in one.
    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q)
            wdog_d = '0;
        else if (state_q == K1_RUN || state_q == K2_RUN)
            wdog_d = wdog_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            drain_q <= '0;
            l_q     <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            l_q     <= l_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    stage_d = '0;
                    state_d = (K1_STAGES == 0) ? K2_RUN : K1_RUN;
                end
            end
            K1_RUN: begin
                if (bus.AGU_done_k1)
                    state_d = K1_GAP;
`ifdef AGU_WDOG_EN
                else if (wdog_trip)
                    state_d = ERR;
`endif
            end
            // Single idle cycle lets the AGU index counter fall back to zero.
            K1_GAP: begin
                stage_d = stage_inc;
                state_d = (stage_inc < K1_LIM) ? K1_RUN : K2_RUN;
            end
            K2_RUN: begin
                if (bus.AGU_done_k2) begin
                    state_d = DRAIN;
                    drain_d = DR_LOAD;
                end
`ifdef AGU_WDOG_EN
                else if (wdog_trip)
                    state_d = ERR;
`endif
            end
            DRAIN: begin
                if (drain_q == '0)
                    state_d = DONE;
                else
                    drain_d = drain_q - 1'b1;
            end
            DONE:    state_d = IDLE;
`ifdef AGU_WDOG_EN
            ERR:     state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            stage_d = '0;
            drain_d = '0;
        end
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        en1_d  = (state_d == K1_RUN);
        en2_d  = (state_d == K2_RUN);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
        l_d    = l_q;
        if (state_d == K1_RUN)
            l_d = stage_d;
        else if (state_d == K2_RUN)
            l_d = L_LAST;
`ifdef AGU_WDOG_EN
        err_d  = (state_d == ERR);
`endif
    end

    assign bus.AGU_enable_k1 = en1_q;
    assign bus.AGU_enable_k2 = en2_q;
    assign bus.l             = l_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule
